// File: rtl/mac_seq_pkg.sv
// Shared types and helpers for the mac_dot_sequencer slice: FSM state
// encoding and the width of the per-vector pair counter.
package mac_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Counter must be able to hold MAX_LEN itself, hence the +1.
   function automatic int cnt_width(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/mac_seq_fifo.sv
// Synchronous operand FIFO of {last, w, x} entries with registered full/empty
// flags; pointers carry an extra MSB to tell full from empty on wrap-around.
module mac_seq_fifo
   import mac_seq_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             push_last,
   input  logic [WIDTH-1:0] push_w,
   input  logic [WIDTH-1:0] push_x,
   input  logic             pop,
   output logic             head_last,
   output logic [WIDTH-1:0] head_w,
   output logic [WIDTH-1:0] head_x,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = 2 * WIDTH + 1;

   logic [EW-1:0] mem_q [DEPTH];
   logic [EW-1:0] mem_d [DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          do_push, do_pop;

   assign do_push = push && !full_q;
   assign do_pop  = pop && !empty_q;

   always_comb begin
      mem_d = mem_q;
      if (do_push) begin
         mem_d[wr_ptr_q[AW-1:0]] = {push_last, push_w, push_x};
      end
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
      empty_d  = (wr_ptr_d == rd_ptr_d);
      full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                 (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Storage needs no reset: the pointers alone decide what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign {head_last, head_w, head_x} = mem_q[rd_ptr_q[AW-1:0]];
   assign full  = full_q;
   assign empty = empty_q;

endmodule

// File: rtl/mac_dot_sequencer.sv
// Feeds operand-pair vectors into a mac_Nbits: clears the MAC, streams pairs,
// pulses vec_done when the sum is final. Optional build macro: MAC_SEQ_ZERO_SKIP_EN.
module mac_dot_sequencer
   import mac_seq_pkg::*;
#(
   parameter  int WIDTH   = 8,
   parameter  int DEPTH   = 4,
   parameter  int MAX_LEN = 64,
   localparam int CW      = cnt_width(MAX_LEN)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_w,
   input  logic [WIDTH-1:0] in_x,
   input  logic             in_last,
   output logic             mac_rst_n,
   output logic             mac_en,
   output logic [WIDTH-1:0] mac_w,
   output logic [WIDTH-1:0] mac_x,
   output logic             vec_done,
   output logic [CW-1:0]    vec_len,
   output logic             len_err
`ifdef MAC_SEQ_ZERO_SKIP_EN
   ,
   output logic [CW-1:0]    skip_cnt
`endif
);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             err_q, err_d;
   logic [CW-1:0]    cnt_inc;
   logic             hit_max;
   logic             pop;
   logic             fifo_full, fifo_empty;
   logic             head_last;
   logic [WIDTH-1:0] head_w, head_x;
`ifdef MAC_SEQ_ZERO_SKIP_EN
   logic [CW-1:0]    skip_q, skip_d;
`endif

   assign in_ready = !fifo_full && !rst;

   mac_seq_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (in_valid && in_ready),
      .push_last (in_last),
      .push_w    (in_w),
      .push_x    (in_x),
      .pop       (pop),
      .head_last (head_last),
      .head_w    (head_w),
      .head_x    (head_x),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign cnt_inc = cnt_q + CW'(1);
   assign hit_max = (cnt_inc == CW'(MAX_LEN));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      pop       = 1'b0;
      mac_en    = 1'b0;
      mac_rst_n = 1'b1;
      vec_done  = 1'b0;
      vec_len   = '0;
      len_err   = 1'b0;
`ifdef MAC_SEQ_ZERO_SKIP_EN
      skip_d    = skip_q;
      skip_cnt  = '0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            mac_rst_n = 1'b0;
            cnt_d     = '0;
            err_d     = 1'b0;
`ifdef MAC_SEQ_ZERO_SKIP_EN
            skip_d    = '0;
`endif
            state_d   = ST_RUN;
         end
         ST_RUN: begin
            // An empty FIFO here is a bubble: the MAC simply holds.
            if (!fifo_empty) begin
               pop   = 1'b1;
               cnt_d = cnt_inc;
`ifdef MAC_SEQ_ZERO_SKIP_EN
               if (head_w == '0 || head_x == '0) skip_d = skip_q + CW'(1);
               else                              mac_en = 1'b1;
`else
               mac_en = 1'b1;
`endif
               if (head_last || hit_max) begin
                  err_d   = !head_last;
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            vec_done = 1'b1;
            vec_len  = cnt_q;
            len_err  = err_q;
`ifdef MAC_SEQ_ZERO_SKIP_EN
            skip_cnt = skip_q;
`endif
            state_d  = fifo_empty ? ST_IDLE : ST_CLEAR;
         end
         default: state_d = ST_IDLE;
      endcase
      // Reset also holds the downstream MAC cleared and silences every pulse.
      if (rst) begin
         pop       = 1'b0;
         mac_en    = 1'b0;
         mac_rst_n = 1'b0;
         vec_done  = 1'b0;
         vec_len   = '0;
         len_err   = 1'b0;
`ifdef MAC_SEQ_ZERO_SKIP_EN
         skip_cnt  = '0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
`ifdef MAC_SEQ_ZERO_SKIP_EN
         skip_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`ifdef MAC_SEQ_ZERO_SKIP_EN
         skip_q  <= skip_d;
`endif
      end
   end

   assign mac_w = mac_en ? head_w : '0;
   assign mac_x = mac_en ? head_x : '0;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Scoreboard bench for mac_dot_sequencer driving a behavioural MAC; expected
// vectors come from a pair-level model of the vector/truncation rules.
module tb_mac_dot_sequencer;

   localparam int WIDTH   = 8;
   localparam int DEPTH   = 4;
   localparam int MAX_LEN = 4;
   localparam int CW      = $clog2(MAX_LEN + 1);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_w = '0;
   logic [WIDTH-1:0] in_x = '0;
   logic             in_last = 1'b0;
   logic             mac_rst_n;
   logic             mac_en;
   logic [WIDTH-1:0] mac_w;
   logic [WIDTH-1:0] mac_x;
   logic             vec_done;
   logic [CW-1:0]    vec_len;
   logic             len_err;
`ifdef MAC_SEQ_ZERO_SKIP_EN
   logic [CW-1:0]    skip_cnt;
`endif

   mac_dot_sequencer #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .MAX_LEN (MAX_LEN)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_w      (in_w),
      .in_x      (in_x),
      .in_last   (in_last),
      .mac_rst_n (mac_rst_n),
      .mac_en    (mac_en),
      .mac_w     (mac_w),
      .mac_x     (mac_x),
      .vec_done  (vec_done),
      .vec_len   (vec_len),
      .len_err   (len_err)
`ifdef MAC_SEQ_ZERO_SKIP_EN
      ,
      .skip_cnt  (skip_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Stand-in for mac_Nbits: clear on low mac_rst_n, 2*WIDTH signed accumulate.
   logic signed [2*WIDTH-1:0] acc = '0;
   always @(posedge clk) begin
      if (!mac_rst_n)  acc <= '0;
      else if (mac_en) acc <= acc + (2*WIDTH)'($signed(mac_w) * $signed(mac_x));
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic signed [2*WIDTH-1:0] sum;
      int                        len;
      bit                        err;
   } exp_t;

   typedef struct {
      logic [WIDTH-1:0] w;
      logic [WIDTH-1:0] x;
   } pair_t;

   exp_t  expQ[$];
   pair_t pairQ[$];
   int    curSum = 0;
   int    curLen = 0;
   int    checks = 0;
   int    errors = 0;
   int    waitCnt = 0;

   task automatic checkOutput(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: a vector closes on last or on reaching MAX_LEN pairs.
   task automatic modelAccept(input int w, input int x, input bit last);
      pair_t p;
      exp_t  e;
      p.w = WIDTH'(w);
      p.x = WIDTH'(x);
      pairQ.push_back(p);
      curSum += int'($signed(p.w)) * int'($signed(p.x));
      curLen++;
      if (last || curLen == MAX_LEN) begin
         e.sum = (2*WIDTH)'(curSum);
         e.len = curLen;
         e.err = !last;
         expQ.push_back(e);
         curSum = 0;
         curLen = 0;
      end
   endtask

   task automatic modelFlush();
      pairQ.delete();
      curSum = 0;
      curLen = 0;
   endtask

   task automatic applyStimulus(input bit v, input int w, input int x, input bit l,
                                output bit accepted);
      @(posedge clk);
      #1;
      in_valid = v;
      in_w     = WIDTH'(w);
      in_x     = WIDTH'(x);
      in_last  = l;
      @(negedge clk);
      accepted = v && in_ready;
      if (accepted) modelAccept(w, x, l);
   endtask

   task automatic sendPair(input int w, input int x, input bit l, output int accCyc);
      bit acc_ok = 1'b0;
      accCyc = -1;
      for (int i = 0; i < 100 && !acc_ok; i++) begin
         applyStimulus(1'b1, w, x, l, acc_ok);
         if (!acc_ok) waitCnt++;
      end
      if (acc_ok) accCyc = cyc;
      else        checkOutput("in_ready_timeout", in_ready, 1);
   endtask

   task automatic idleCycles(input int n);
      bit dummy;
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 1'b0, dummy);
   endtask

   task automatic waitDone(output int doneCyc);
      bit dummy;
      doneCyc = -1;
      for (int i = 0; i < 60; i++) begin
         applyStimulus(1'b0, 0, 0, 1'b0, dummy);
         if (vec_done) begin
            doneCyc = cyc;
            break;
         end
      end
      checkOutput("vec_done_seen", vec_done, 1);
   endtask

   // Monitor: pops expected pairs on every MAC enable and expected vectors on vec_done.
   always @(negedge clk) begin
      if (rst) begin
         checkOutput("rst_in_ready", in_ready, 0);
         checkOutput("rst_mac_rst_n", mac_rst_n, 0);
         checkOutput("rst_vec_done", vec_done, 0);
         checkOutput("rst_mac_en", mac_en, 0);
      end else begin
         if (mac_en) begin
            if (pairQ.size() == 0) begin
               checkOutput("unexpected_mac_en", mac_en, 0);
            end else begin
               pair_t p;
               p = pairQ.pop_front();
               checkOutput("mac_w", mac_w, p.w);
               checkOutput("mac_x", mac_x, p.x);
            end
         end else begin
            checkOutput("mac_w_idle_zero", mac_w, 0);
            checkOutput("mac_x_idle_zero", mac_x, 0);
         end
         if (vec_done) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_vec_done", vec_done, 0);
            end else begin
               exp_t e;
               e = expQ.pop_front();
               checkOutput("dot_sum", acc, e.sum);
               checkOutput("vec_len", vec_len, e.len);
               checkOutput("len_err", len_err, e.err);
            end
         end else begin
            checkOutput("len_err_no_done", len_err, 0);
         end
      end
   end

   initial begin
      int  c0, c1, d0, d1;
      bit  dummy;

      $display("[TB] reset");
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 0, 1'b0, dummy);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_mac_rst_n", mac_rst_n, 1);
      checkOutput("post_rst_mac_en", mac_en, 0);
      checkOutput("post_rst_vec_done", vec_done, 0);
      checkOutput("post_rst_vec_len", vec_len, 0);
      checkOutput("post_rst_len_err", len_err, 0);
      checkOutput("post_rst_in_ready", in_ready, 1);
      checkOutput("post_rst_acc", acc, 0);

      $display("[TB] two-pair vector");
      sendPair(-3, 2, 1'b0, c0);
      sendPair(5, -4, 1'b1, c1);
      waitDone(d0);
      checkOutput("two_pair_sum", acc, -26);
      checkOutput("two_pair_len", vec_len, 2);
      checkOutput("two_pair_latency", d0 - c0, 5);
      idleCycles(3);

      $display("[TB] back-to-back vectors");
      sendPair(6, -8, 1'b1, c0);
      sendPair(-8, -4, 1'b1, c1);
      waitDone(d0);
      checkOutput("b2b_first_sum", acc, -48);
      waitDone(d1);
      checkOutput("b2b_second_sum", acc, 32);
      checkOutput("b2b_spacing", d1 - d0, 3);
      idleCycles(3);

      $display("[TB] bubbles");
      sendPair(7, 3, 1'b0, c0);
      idleCycles(3);
      sendPair(-2, 5, 1'b0, c1);
      sendPair(4, -6, 1'b1, c1);
      waitDone(d0);
      checkOutput("bubble_sum", acc, -13);
      idleCycles(3);

      $display("[TB] backpressure");
      waitCnt = 0;
      for (int i = 0; i < 6; i++) sendPair(i + 1, -(i + 2), 1'b1, c0);
      checkOutput("backpressure_seen", waitCnt > 0, 1);
      idleCycles(30);

      $display("[TB] truncation");
      for (int i = 1; i <= 5; i++) sendPair(i, i, i == 5, c0);
      waitDone(d0);
      checkOutput("trunc_len", vec_len, 4);
      checkOutput("trunc_err", len_err, 1);
      checkOutput("trunc_sum", acc, 30);
      waitDone(d1);
      checkOutput("trunc_tail_len", vec_len, 1);
      checkOutput("trunc_tail_err", len_err, 0);
      checkOutput("trunc_tail_sum", acc, 25);
      idleCycles(3);

      $display("[TB] reset mid-vector");
      sendPair(1, 2, 1'b0, c0);
      sendPair(3, 4, 1'b0, c1);
      idleCycles(2);
      @(posedge clk);
      #1 rst = 1'b1;
      in_valid = 1'b0;
      modelFlush();
      checkOutput("midrst_exp_empty", expQ.size(), 0);
      @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_acc_cleared", acc, 0);
      idleCycles(8);
      sendPair(2, 3, 1'b1, c0);
      waitDone(d0);
      checkOutput("midrst_fresh_sum", acc, 6);
      idleCycles(3);

      $display("[TB] random vectors");
      for (int v = 0; v < 150; v++) begin
         int len;
         len = int'($urandom_range(1, 6));
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) idleCycles(int'($urandom_range(1, 2)));
            sendPair(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                     i == len - 1, c0);
         end
         if ($urandom_range(0, 4) == 0) idleCycles(int'($urandom_range(1, 5)));
      end

      for (int i = 0; i < 300 && (expQ.size() != 0 || pairQ.size() != 0); i++) idleCycles(1);
      idleCycles(5);
      checkOutput("exp_queue_drained", expQ.size(), 0);
      checkOutput("pair_queue_drained", pairQ.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
